// File: rtl/bcd_display_scanner.sv
// Double-buffered, time-multiplexed driver for a 5-digit common-anode 7-segment display.
// Pending digits are promoted to the shown buffer only at frame boundaries.
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int DP_POS      = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] first,
    input  logic [3:0] second,
    input  logic [3:0] third,
    input  logic [3:0] fourth,
    input  logic [3:0] fifth,
    output logic [4:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [2:0] IDX_LAST = 3'd4;
    localparam logic [2:0] IDX_DP = 3'(DP_POS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [19:0]   pending_q, pending_d;
    logic          pending_valid_q, pending_valid_d;
    logic [19:0]   shown_q, shown_d;
    logic [4:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    digits [5];
    logic [4:0]    lz_run;
    logic [3:0]    cur_digit;
    logic          cur_lz;
    logic          blank_cur;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Scan counters
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Buffers: a load coinciding with the boundary lands in pending and stays valid,
    // because the load assignment overrides the boundary's clear.
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        shown_d         = shown_q;
        frame_done_d    = frame_end;
        if (frame_end && pending_valid_q) begin
            shown_d         = pending_q;
            pending_valid_d = 1'b0;
        end
        if (load) begin
            pending_d       = {first, second, third, fourth, fifth};
            pending_valid_d = 1'b1;
        end
    end

    // Digit selection and leading-zero run over the shown buffer
    always_comb begin
        logic run;
        run       = 1'b1;
        lz_run    = '0;
        cur_digit = '0;
        cur_lz    = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            digits[i] = shown_q[19 - 4*i -: 4];
            run       = run && (digits[i] == 4'd0);
            lz_run[i] = run;
        end
        for (int unsigned i = 0; i < 5; i++) begin
            if (idx_q == 3'(i)) begin
                cur_digit = digits[i];
                cur_lz    = lz_run[i];
            end
        end
        blank_cur = (BLANK_LZ != 0) && (idx_q < IDX_DP) && cur_lz;
    end

    // Registered display outputs, one cycle behind cnt/idx
    always_comb begin
        an_d  = 5'b11111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (cnt_q >= CNT_GUARD) begin
            an_d  = ~(5'b10000 >> idx_q);
            seg_d = blank_cur ? 7'h7F : decode(cur_digit);
            dp_d  = ~(idx_q == IDX_DP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            shown_q         <= '0;
            an_q            <= 5'b11111;
            seg_q           <= 7'h7F;
            dp_q            <= 1'b1;
            frame_done_q    <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            shown_q         <= shown_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with a 4-cycle slot and 1-cycle guard.
module tb_bcd_display_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] first, second, third, fourth, fifth;
    logic [4:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    bcd_display_scanner #(
        .REFRESH_DIV(4),
        .GUARD      (1),
        .DP_POS     (1),
        .BLANK_LZ   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .first     (first),
        .second    (second),
        .third     (third),
        .fourth    (fourth),
        .fifth     (fifth),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(input string tag);
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = (frame_done === 1'b1);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: observed no frame_done expected pulse within 50 cycles", tag);
        end
    endtask

    // Starts on a negedge where frame_done is high; checks the next 20 negedges
    // ({an,seg,dp,frame_done}) and optionally pulses load at steps ka / kb.
    task automatic check_frame(input string name, input logic [34:0] segs,
                               input int ka, input logic [19:0] da,
                               input int kb, input logic [19:0] db);
        for (int k = 1; k <= 20; k++) begin
            int s, p;
            logic [4:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            @(negedge clk);
            if ((ka > 0 && k == ka + 1) || (kb > 0 && k == kb + 1)) load = 1'b0;
            s = (k - 1) / 4;
            p = (k - 1) % 4;
            if (p == 0) begin
                e_an = 5'b11111; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = ~(5'b10000 >> s);
                e_seg = segs[34 - 7*s -: 7];
                e_dp  = (s != 1);
            end
            chk($sformatf("%s k%0d", name, k), {18'd0, an, seg, dp, frame_done},
                {18'd0, e_an, e_seg, e_dp, (k == 20)});
            if (k == ka) begin
                {first, second, third, fourth, fifth} = da; load = 1'b1;
            end
            if (k == kb) begin
                {first, second, third, fourth, fifth} = db; load = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        {first, second, third, fourth, fifth} = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset outputs", {18'd0, an, seg, dp, frame_done}, {18'd0, 5'b11111, 7'h7F, 1'b1, 1'b0});
        rst = 1'b0;

        wait_fd("first frame_done");
        // Zeros: slot0 blanked, slot1 "0." ; load 1,3,4,1,6 early in the frame
        check_frame("zeros", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 1, 20'h13416, 0, '0);
        // 13.416 shown; 8,8,8,8,8 overwritten by 0,2,0,0,0 loaded mid-frame at idx 2
        check_frame("13416", {7'h79, 7'h30, 7'h19, 7'h79, 7'h02}, 5, 20'h88888, 9, 20'h02000);
        check_frame("02000", {7'h7F, 7'h24, 7'h40, 7'h40, 7'h40}, 1, 20'h98C75, 0, '0);
        // Error glyph on third; early load X then load Y coincident with the boundary
        check_frame("98C75", {7'h10, 7'h00, 7'h3F, 7'h78, 7'h12}, 1, 20'h00007, 19, 20'h25013);
        check_frame("00007", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h78}, 0, '0, 0, '0);
        check_frame("25013", {7'h24, 7'h12, 7'h40, 7'h79, 7'h30}, 0, '0, 0, '0);

        // Load 9s, then reset during slot 3: pending must be lost
        @(negedge clk);
        @(negedge clk);
        {first, second, third, fourth, fifth} = 20'h99999;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (11) @(negedge clk);
        chk("slot3 before reset", {18'd0, an, seg, dp, frame_done}, {18'd0, 5'b11101, 7'h79, 1'b1, 1'b0});
        rst = 1'b1;
        #1;
        chk("async reset", {18'd0, an, seg, dp, frame_done}, {18'd0, 5'b11111, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        wait_fd("frame_done after reset");
        check_frame("post-reset", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 0, '0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
